rotary_paddle: RTL and testbench



---
 rtl/rotary_paddle_if.sv | 21 ++
 rtl/rotary_paddle.sv | 134 +++++++++++++
 tb/tb_rotary_paddle.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rotary_paddle_if.sv
// Signal bundle between the rotary encoder conditioner and its neighbours.
// The master side drives the raw encoder phases and the frame tick; the slave side is the conditioner.
interface rotary_paddle_if;
    logic       rota;
    logic       rotb;
    logic       frame_tick;
    logic [9:0] paddle_y;
    logic       step_up;
    logic       step_dn;
    logic       quad_err;

    modport master (
        output rota, rotb, frame_tick,
        input  paddle_y, step_up, step_dn, quad_err
    );

    modport slave (
        input  rota, rotb, frame_tick,
        output paddle_y, step_up, step_dn, quad_err
    );
endinterface

// File: rtl/rotary_paddle.sv
// Rotary encoder conditioner: sync + debounce both phases, decode full detents into
// up/down steps, keep a saturating paddle coordinate and publish it on frame_tick.
module rotary_paddle #(
    parameter int DEB_CYCLES = 50000,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 400,
    parameter int POS_INIT   = 200,
    parameter int STEP       = 8
) (
    input  logic             clk25,
    input  logic             reset,
    rotary_paddle_if.slave   bus
);
    localparam logic [16:0]       DEB_LAST = 17'(DEB_CYCLES - 1);
    localparam logic [10:0]       P_MIN    = 11'(POS_MIN);
    localparam logic [10:0]       P_MAX    = 11'(POS_MAX);
    localparam logic [10:0]       P_INIT   = 11'(POS_INIT);
    localparam logic [10:0]       P_STEP   = 11'(STEP);
    localparam logic signed [2:0] ACC_HI   = 3'sd3;
    localparam logic signed [2:0] ACC_LO   = -3'sd3;

    // Bit 1 is phase A, bit 0 is phase B, so the vector reads as {A,B}.
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {bus.rota, bus.rotb};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic        r_s1;
            logic        r_s2;
            logic        r_filt;
            logic [16:0] r_cnt;

            // A mismatch must persist DEB_CYCLES consecutive cycles; one matching cycle restarts the count.
            always_ff @(posedge clk25 or posedge reset) begin
                if (reset) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_filt <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_filt <= r_s2;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic [1:0]        r_prev_q;
    logic [1:0]        w_idx;
    logic [1:0]        w_prev_idx;
    logic [1:0]        w_delta;
    logic              w_fwd;
    logic              w_rev;
    logic              w_ill;
    logic              w_up_hit;
    logic              w_dn_hit;
    logic signed [2:0] r_acc;
    logic [10:0]       r_pos;
    logic [10:0]       w_pos_sum;
    logic [10:0]       w_pos_up;
    logic [10:0]       w_pos_dn;
    logic [9:0]        r_paddle_y;
    logic              r_step_up;
    logic              r_step_dn;
    logic              r_quad_err;

    // Map the Gray sequence 00,10,11,01 onto 0..3 so a transition is just an index difference mod 4.
    assign w_idx      = {w_filt[0], w_filt[1] ^ w_filt[0]};
    assign w_prev_idx = {r_prev_q[0], r_prev_q[1] ^ r_prev_q[0]};
    assign w_delta    = w_idx - w_prev_idx;
    assign w_fwd      = (w_delta == 2'd1);
    assign w_rev      = (w_delta == 2'd3);
    assign w_ill      = (w_delta == 2'd2);
    assign w_up_hit   = w_fwd && (r_acc == ACC_HI);
    assign w_dn_hit   = w_rev && (r_acc == ACC_LO);

    assign w_pos_sum  = r_pos + P_STEP;
    assign w_pos_up   = (w_pos_sum > P_MAX) ? P_MAX : w_pos_sum;
    assign w_pos_dn   = (r_pos < P_MIN + P_STEP) ? P_MIN : (r_pos - P_STEP);

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            r_prev_q   <= 2'b00;
            r_acc      <= '0;
            r_pos      <= P_INIT;
            r_paddle_y <= P_INIT[9:0];
            r_step_up  <= 1'b0;
            r_step_dn  <= 1'b0;
            r_quad_err <= 1'b0;
        end else begin
            r_prev_q   <= w_filt;
            r_step_up  <= w_up_hit;
            r_step_dn  <= w_dn_hit;
            r_quad_err <= w_ill;

            if (w_up_hit || w_dn_hit) begin
                r_acc <= '0;
            end else if (w_fwd) begin
                r_acc <= r_acc + 3'sd1;
            end else if (w_rev) begin
                r_acc <= r_acc - 3'sd1;
            end

            if (w_up_hit) begin
                r_pos <= w_pos_up;
            end else if (w_dn_hit) begin
                r_pos <= w_pos_dn;
            end

            // Publishes the pre-update position when a step lands on the tick edge.
            if (bus.frame_tick) begin
                r_paddle_y <= r_pos[9:0];
            end
        end
    end

    assign bus.paddle_y = r_paddle_y;
    assign bus.step_up  = r_step_up;
    assign bus.step_dn  = r_step_dn;
    assign bus.quad_err = r_quad_err;
endmodule

// File: tb/tb_rotary_paddle.sv
// Self-checking bench for rotary_paddle: expected step/error pulses are queued with
// their due cycle when stimulus is driven and matched against observed pulses.
module tb_rotary_paddle;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int K_UP = 1;
    localparam int K_DN = 2;
    localparam int K_ER = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk25;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    rotary_paddle_if bus ();

    rotary_paddle #(
        .DEB_CYCLES (DEB),
        .POS_MIN    (0),
        .POS_MAX    (400),
        .POS_INIT   (200),
        .STEP       (8)
    ) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    initial cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    // Record every output pulse with the cycle it was seen in.
    always @(negedge clk25) begin
        if (!reset) begin
            if (bus.step_up)  obs_q.push_back('{K_UP, cyc});
            if (bus.step_dn)  obs_q.push_back('{K_DN, cyc});
            if (bus.quad_err) obs_q.push_back('{K_ER, cyc});
        end
    end

    task automatic chk_val(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic drive_ab(input logic a, input logic b, input int kind);
        @(posedge clk25);
        #1;
        bus.rota = a;
        bus.rotb = b;
        if (kind != 0) exp_q.push_back('{kind, cyc + DEB + 3});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk25);
    endtask

    task automatic detent_cw();
        drive_ab(1'b1, 1'b0, 0); wait_cyc(HOLD);
        drive_ab(1'b1, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b0, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b0, 1'b0, K_UP); wait_cyc(HOLD);
    endtask

    task automatic detent_ccw();
        drive_ab(1'b0, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b1, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b1, 1'b0, 0); wait_cyc(HOLD);
        drive_ab(1'b0, 1'b0, K_DN); wait_cyc(HOLD);
    endtask

    task automatic pulse_tick();
        @(posedge clk25);
        #1 bus.frame_tick = 1'b1;
        @(posedge clk25);
        #1 bus.frame_tick = 1'b0;
    endtask

    task automatic tick_and_check(input string tag, input int want);
        pulse_tick();
        chk_val(tag, int'(bus.paddle_y), want);
    endtask

    task automatic do_reset(input logic a, input logic b);
        @(posedge clk25);
        #1;
        reset          = 1'b1;
        bus.rota       = a;
        bus.rotb       = b;
        bus.frame_tick = 1'b0;
        #1;
        chk_val("rst_paddle_y", int'(bus.paddle_y), 200);
        chk_val("rst_pulses", int'({bus.step_up, bus.step_dn, bus.quad_err}), 0);
        wait_cyc(3);
        #1 reset = 1'b0;
        if (a && b) exp_q.push_back('{K_ER, cyc + DEB + 3});
    endtask

    // Bounded wait for the queued pulses, then pairwise comparison of kind and cycle.
    task automatic drain(input string tag);
        int  w;
        int  n_e;
        ev_t e;
        ev_t o;
        w = 0;
        while (obs_q.size() < exp_q.size() && w < 200) begin
            @(posedge clk25);
            w++;
        end
        wait_cyc(12);
        n_e = exp_q.size();
        chk_val({tag, "_count"}, obs_q.size(), n_e);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk_val({tag, "_missing"}, 0, e.kind);
            end else begin
                o = obs_q.pop_front();
                chk_val({tag, "_kind"}, o.kind, e.kind);
                chk_val({tag, "_cycle"}, o.cyc, e.cyc);
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk_val({tag, "_extra"}, o.kind, 0);
        end
        $display("drain %s: %0d events expected", tag, n_e);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        bus.rota       = 1'b0;
        bus.rotb       = 1'b0;
        bus.frame_tick = 1'b0;

        // Idle after reset with periodic frame ticks.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_cyc(98);
            tick_and_check("idle_paddle_y", 200);
        end
        drain("idle");

        // One clean clockwise detent; published only at the next tick.
        detent_cw();
        wait_cyc(10);
        chk_val("cw_before_tick", int'(bus.paddle_y), 200);
        tick_and_check("cw_after_tick", 208);
        drain("cw");

        // Detent completes on the same edge as frame_tick: old value is published.
        drive_ab(1'b1, 1'b0, 0); wait_cyc(HOLD);
        drive_ab(1'b1, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b0, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b0, 1'b0, K_UP);
        wait_cyc(6);
        #1 bus.frame_tick = 1'b1;
        @(posedge clk25);
        #1 bus.frame_tick = 1'b0;
        chk_val("same_edge_old", int'(bus.paddle_y), 208);
        tick_and_check("same_edge_new", 216);
        drain("same_edge");

        // 60 counter-clockwise detents saturate at the bottom.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) detent_ccw();
        tick_and_check("ccw_sat_bottom", 0);
        drain("ccw60");

        // Glitch on A shorter than the debounce window.
        drive_ab(1'b1, 1'b0, 0);
        wait_cyc(2);
        drive_ab(1'b0, 1'b0, 0);
        wait_cyc(20);
        drain("glitch");
        tick_and_check("glitch_paddle_y", 0);

        // Illegal jump 00->11 and back.
        drive_ab(1'b1, 1'b1, K_ER);
        wait_cyc(20);
        drain("illegal_up");
        drive_ab(1'b0, 1'b0, K_ER);
        wait_cyc(20);
        drain("illegal_dn");
        tick_and_check("illegal_paddle_y", 0);

        // Half detent forward then back, followed by a full detent giving exactly one step.
        drive_ab(1'b1, 1'b0, 0); wait_cyc(HOLD);
        drive_ab(1'b1, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b1, 1'b0, 0); wait_cyc(HOLD);
        drive_ab(1'b0, 1'b0, 0); wait_cyc(HOLD);
        drain("half_back");
        detent_cw();
        tick_and_check("after_half_paddle_y", 8);
        drain("after_half");

        // Reset in the middle of a detent discards the partial count.
        drive_ab(1'b1, 1'b0, 0); wait_cyc(HOLD);
        drive_ab(1'b1, 1'b1, 0); wait_cyc(HOLD);
        drive_ab(1'b0, 1'b1, 0); wait_cyc(HOLD);
        do_reset(1'b0, 1'b0);
        wait_cyc(10);
        detent_cw();
        tick_and_check("mid_reset_paddle_y", 208);
        drain("mid_reset");

        // Inputs already high at reset release register as an illegal jump.
        do_reset(1'b1, 1'b1);
        wait_cyc(20);
        drain("rel_high");
        drive_ab(1'b0, 1'b0, K_ER);
        wait_cyc(20);
        drain("rel_high_back");
        detent_cw();
        tick_and_check("rel_high_paddle_y", 208);
        drain("rel_high_cw");

        // Clockwise saturation at the top.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) detent_cw();
        tick_and_check("cw_sat_top", 400);
        drain("cw30");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
